dual_writeback_queue: RTL

//   Writeback buffer directly upstream of the dual-write-port 32x32 register file.

---
 rtl/dual_writeback_queue_pkg.sv | 16 +
 rtl/dual_writeback_queue_if.sv | 31 +++
 rtl/dual_writeback_queue_storage.sv | 33 +++
 rtl/dual_writeback_queue.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dual_writeback_queue_pkg.sv
// Shared types for the dual writeback queue: entry layout and pop-case encoding.
package wbq_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {POP_NONE, POP_ONE, POP_TWO, POP_COALESCE} pop_case_e;

  function automatic logic [1:0] pop_count(pop_case_e pc);
    return (pc == POP_NONE) ? 2'd0 : ((pc == POP_ONE) ? 2'd1 : 2'd2);
  endfunction
endpackage

// File: rtl/dual_writeback_queue_if.sv
// Execute-side request pair and register-file-side write pair of the writeback queue.
interface dual_writeback_queue_if;
  import wbq_pkg::*;

  logic                  In1Valid;
  logic [REG_ADDR_W-1:0] In1Reg;
  logic [DATA_W-1:0]     In1Data;
  logic                  In2Valid;
  logic [REG_ADDR_W-1:0] In2Reg;
  logic [DATA_W-1:0]     In2Data;
  logic                  InReady;
  logic                  RegWrite1;
  logic [REG_ADDR_W-1:0] WriteRegister1;
  logic [DATA_W-1:0]     WriteData1;
  logic                  RegWrite2;
  logic [REG_ADDR_W-1:0] WriteRegister2;
  logic [DATA_W-1:0]     WriteData2;
  logic                  Empty;

  modport master (
    output In1Valid, In1Reg, In1Data, In2Valid, In2Reg, In2Data,
    input  InReady, RegWrite1, WriteRegister1, WriteData1,
           RegWrite2, WriteRegister2, WriteData2, Empty
  );

  modport slave (
    input  In1Valid, In1Reg, In1Data, In2Valid, In2Reg, In2Data,
    output InReady, RegWrite1, WriteRegister1, WriteData1,
           RegWrite2, WriteRegister2, WriteData2, Empty
  );
endinterface

// File: rtl/dual_writeback_queue_storage.sv
// Entry array for the writeback queue: two adjacent write slots, two adjacent read slots.
module wbq_storage
  import wbq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] wptr,
  input  wb_entry_t                wdata0,
  input  wb_entry_t                wdata1,
  input  logic [$clog2(DEPTH)-1:0] rptr,
  output wb_entry_t                rdata0,
  output wb_entry_t                rdata1
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wptr1;
  logic [PTR_W-1:0] rptr1;

  // Pointer arithmetic wraps naturally at the power-of-two depth.
  assign wptr1  = wptr + PTR_W'(1);
  assign rptr1  = rptr + PTR_W'(1);
  assign rdata0 = mem_q[rptr];
  assign rdata1 = mem_q[rptr1];

  always_ff @(posedge Clk) begin
    if (we0) mem_q[wptr]  <= wdata0;
    if (we1) mem_q[wptr1] <= wdata1;
  end
endmodule

// File: rtl/dual_writeback_queue.sv
// In-order two-in/two-out writeback queue feeding a dual-write-port register file.
// Optional macro WBQ_STATS_EN adds a saturating CoalesceCount output.
module dual_writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input logic                  Clk,
  input logic                  Reset,
  dual_writeback_queue_if.slave wb
`ifdef WBQ_STATS_EN
  ,
  output logic [15:0]          CoalesceCount
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push1, push2, we0, we1;
  logic [1:0]       n_push, n_pop;
  wb_entry_t        wdata0, wdata1, head0, head1;
  pop_case_e        pop_case;
  logic             rw1_q, rw1_d, rw2_q, rw2_d;
  wb_entry_t        port1_q, port1_d, port2_q, port2_d;

  assign wb.InReady = (count_q <= CNT_W'(DEPTH - 2));
  assign wb.Empty   = (count_q == '0);

  // r0 requests are accepted but never stored when ZERO_DISCARD is set.
  assign push1 = wb.InReady && wb.In1Valid && !(ZERO_DISCARD && (wb.In1Reg == '0));
  assign push2 = wb.InReady && wb.In2Valid && !(ZERO_DISCARD && (wb.In2Reg == '0));
  assign we0   = push1 | push2;
  assign we1   = push1 & push2;
  assign wdata0 = push1 ? wb_entry_t'{addr: wb.In1Reg, data: wb.In1Data}
                        : wb_entry_t'{addr: wb.In2Reg, data: wb.In2Data};
  assign wdata1 = wb_entry_t'{addr: wb.In2Reg, data: wb.In2Data};
  assign n_push = {1'b0, we0} + {1'b0, we1};

  wbq_storage #(.DEPTH(DEPTH)) u_storage (
    .Clk    (Clk),
    .we0    (we0),
    .we1    (we1),
    .wptr   (wptr_q),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rptr   (rptr_q),
    .rdata0 (head0),
    .rdata1 (head1)
  );

  // Pop decision looks only at entries present before this edge's push.
  always_comb begin
    pop_case = POP_NONE;
    if (count_q == CNT_W'(1)) begin
      pop_case = POP_ONE;
    end else if (count_q >= CNT_W'(2)) begin
      pop_case = (head0.addr == head1.addr) ? POP_COALESCE : POP_TWO;
    end
  end

  always_comb begin
    rw1_d   = 1'b0;
    rw2_d   = 1'b0;
    port1_d = port1_q;
    port2_d = port2_q;
    case (pop_case)
      POP_ONE: begin
        rw1_d   = 1'b1;
        port1_d = head0;
      end
      POP_TWO: begin
        rw1_d   = 1'b1;
        rw2_d   = 1'b1;
        port1_d = head0;
        port2_d = head1;
      end
      // Same destination twice: only the younger value survives.
      POP_COALESCE: begin
        rw2_d   = 1'b1;
        port2_d = head1;
      end
      default: ;
    endcase
  end

  assign n_pop   = pop_count(pop_case);
  assign rptr_d  = rptr_q + PTR_W'(n_pop);
  assign wptr_d  = wptr_q + PTR_W'(n_push);
  assign count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      rw1_q   <= 1'b0;
      rw2_q   <= 1'b0;
      port1_q <= '0;
      port2_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      rw1_q   <= rw1_d;
      rw2_q   <= rw2_d;
      port1_q <= port1_d;
      port2_q <= port2_d;
    end
  end

  assign wb.RegWrite1      = rw1_q;
  assign wb.WriteRegister1 = port1_q.addr;
  assign wb.WriteData1     = port1_q.data;
  assign wb.RegWrite2      = rw2_q;
  assign wb.WriteRegister2 = port2_q.addr;
  assign wb.WriteData2     = port2_q.data;

`ifdef WBQ_STATS_EN
  logic [15:0] coal_cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      coal_cnt_q <= '0;
    end else if ((pop_case == POP_COALESCE) && (coal_cnt_q != 16'hFFFF)) begin
      coal_cnt_q <= coal_cnt_q + 16'd1;
    end
  end

  assign CoalesceCount = coal_cnt_q;
`endif
endmodule
